// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared FSM states, op encoding and slice width for the CLA word sequencer
package cla_seq_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COLLECT, DONE} state_t;
    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;
    localparam int   SLICE_W = 4;
endpackage

// File: rtl/cla4_reg.sv
// cla4_reg: 4-bit carry-lookahead adder slice with registered inputs and registered S/Cout
// Ports: clk, rst (sync active-high); A, B, Cin slice inputs; S, Cout registered results (2-edge latency)
module cla4_reg
    import cla_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               Cin,
    output logic [SLICE_W-1:0] S,
    output logic               Cout
);
    logic [SLICE_W-1:0] r_a, r_b, w_g, w_p;
    logic               r_c;
    logic [SLICE_W:0]   w_c;
    assign w_g = r_a & r_b;
    assign w_p = r_a ^ r_b;
    // Every carry is expanded from generate/propagate terms instead of rippling
    assign w_c[0] = r_c;
    assign w_c[1] = w_g[0] | (w_p[0] & r_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & r_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0]) | (&w_p[2:0] & r_c);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1]) | (&w_p[3:1] & w_g[0])
                  | (&w_p & r_c);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_c  <= 1'b0;
            S    <= '0;
            Cout <= 1'b0;
        end else begin
            r_a  <= A;
            r_b  <= B;
            r_c  <= Cin;
            S    <= w_p ^ w_c[SLICE_W-1:0];
            Cout <= w_c[SLICE_W];
        end
    end
endmodule

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: multi-precision add/subtract through one shared 4-bit CLA slice, nibble by nibble
// Ports: clk, rst (sync active-high); in_valid/in_ready operand handshake with a, b, cin, op (0 add, 1 a-b);
//        out_valid/out_ready result handshake with sum, cout (subtract: 1 = no borrow); busy = not idle
module cla_word_sequencer
    import cla_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*NIBBLES-1:0] a,
    input  logic [SLICE_W*NIBBLES-1:0] b,
    input  logic                       cin,
    input  logic                       op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*NIBBLES-1:0] sum,
    output logic                       cout,
    output logic                       busy
);
    localparam int W  = SLICE_W * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    state_t             r_state, w_next;
    logic [W-1:0]       r_opa, r_opb, r_sum;
    logic [IW-1:0]      r_idx;
    logic               r_carry, r_cout, w_last, w_issue, w_co;
    logic [SLICE_W-1:0] w_sa, w_sb, w_s;
    assign w_last  = r_idx == IW'(NIBBLES - 1);
    assign w_issue = r_state == ISSUE;
    // The slice sees zeros outside ISSUE so stale nibbles never linger in its input register
    assign w_sa = w_issue ? r_opa[SLICE_W*r_idx +: SLICE_W] : '0;
    assign w_sb = w_issue ? r_opb[SLICE_W*r_idx +: SLICE_W] : '0;
    cla4_reg u_slice (
        .clk  (clk),
        .rst  (rst),
        .A    (w_sa),
        .B    (w_sb),
        .Cin  (w_issue & r_carry),
        .S    (w_s),
        .Cout (w_co)
    );
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = COLLECT;
            COLLECT: w_next = w_last ? DONE : ISSUE;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            // Subtract is a + ~b + 1, so the inversion and forced carry happen once at capture
            r_opa   <= a;
            r_opb   <= op == OP_SUB ? ~b : b;
            r_carry <= op == OP_SUB ? 1'b1 : cin;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (r_state == COLLECT) begin
            r_sum[SLICE_W*r_idx +: SLICE_W] <= w_s;
            r_carry <= w_co;
            if (w_last) r_cout <= w_co;
            else        r_idx  <= r_idx + 1'b1;
        end
    end
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign sum       = r_sum;
    assign cout      = r_cout;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// tb_cla_word_sequencer: randomized + directed bench against a cycle-count/arithmetic reference model
module tb_cla_word_sequencer;
    localparam int N  = 4;
    localparam int W  = 4 * N;
    localparam int DT = 3 * N + 1;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, op = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic in_ready, out_valid, cout, busy;
    logic [W-1:0] sum;
    logic in_valid1 = 1'b0, out_ready1 = 1'b0, cin1 = 1'b0, op1 = 1'b0;
    logic [3:0] a1 = '0, b1 = '0, sum1;
    logic in_ready1, out_valid1, cout1, busy1;
    int asserts = 0, errs = 0;
    logic chk_en = 1'b0;
    int m_t = 0;
    logic [W:0] m_res = '0;
    logic [W-1:0] m_last_sum = '0;
    logic m_last_cout = 1'b0;

    always #5 clk = ~clk;

    cla_word_sequencer #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .busy(busy)
    );
    cla_word_sequencer #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .cin(cin1), .op(op1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
        .cout(cout1), .busy(busy1)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        asserts++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: m_t counts cycles since acceptance (0 = idle, DT = result presented)
    always @(posedge clk) begin
        if (rst) begin
            m_t = 0;
            m_last_sum = '0;
            m_last_cout = 1'b0;
        end else if (m_t == 0) begin
            if (in_valid) begin
                m_t = 1;
                m_res = {1'b0, a} + {1'b0, (op ? ~b : b)} + (W+1)'(op ? 1'b1 : cin);
            end
        end else if (m_t < DT) begin
            m_t++;
        end else if (out_ready) begin
            m_t = 0;
            m_last_sum = m_res[W-1:0];
            m_last_cout = m_res[W];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [W-1:0] mask, exp_sum;
            mask = '0;
            for (int k = 0; k < (m_t - 1) / 3; k++) mask[4*k +: 4] = 4'hF;
            exp_sum = m_t == 0 ? m_last_sum : m_res[W-1:0] & mask;
            chk("in_ready", 32'(in_ready), 32'(m_t == 0));
            chk("busy", 32'(busy), 32'(m_t != 0));
            chk("out_valid", 32'(out_valid), 32'(m_t == DT));
            chk("sum", 32'(sum), 32'(exp_sum));
            if (m_t == 0 || m_t == DT)
                chk("cout", 32'(cout), 32'(m_t == 0 ? m_last_cout : m_res[W]));
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic to, input int hold,
                          output logic [W-1:0] rs, output logic rc, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        a = ta; b = tb; cin = tc; op = to; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk("timeout", 32'(out_valid), 32'd1);
        rs = sum;
        rc = cout;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_sum", 32'(sum), 32'(rs));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ready_after_done", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] rs;
        logic rc;
        int lat;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sum", 32'(sum), 32'd0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, rs, rc, lat);
        chk("ffff_sum", 32'(rs), 32'h0000FFFF);
        chk("ffff_cout", 32'(rc), 32'd1);
        chk("ffff_lat", 32'(lat), 32'd13);
        run_op(16'hAAAA, 16'hCCCC, 1'b1, 1'b0, 0, rs, rc, lat);
        chk("aacc_sum", 32'(rs), 32'h00007777);
        chk("aacc_cout", 32'(rc), 32'd1);
        run_op(16'h000A, 16'h0008, 1'b0, 1'b0, 0, rs, rc, lat);
        chk("a8_sum", 32'(rs), 32'h00000012);
        chk("a8_cout", 32'(rc), 32'd0);
        run_op(16'h1000, 16'h0001, 1'b0, 1'b1, 5, rs, rc, lat);
        chk("sub1_sum", 32'(rs), 32'h00000FFF);
        chk("sub1_cout", 32'(rc), 32'd1);
        run_op(16'h0001, 16'h0002, 1'b1, 1'b1, 0, rs, rc, lat);
        chk("sub2_sum", 32'(rs), 32'h0000FFFF);
        chk("sub2_cout", 32'(rc), 32'd0);
        // Reset during cycle 6 of an add
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0, rs, rc, lat);
        chk("after_rst_sum", 32'(rs), 32'h00000007);
        // Reset coinciding with a request must win
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_wins_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 30; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), rs, rc, lat);
        // Single-slice instance
        @(negedge clk);
        a1 = 4'hA; b1 = 4'h8; cin1 = 1'b0; op1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0; a1 = 4'h5;
        lat = 1;
        while (!out_valid1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("n1_lat", 32'(lat), 32'd4);
        chk("n1_sum", 32'(sum1), 32'h2);
        chk("n1_cout", 32'(cout1), 32'd1);
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        chk("n1_idle", 32'(in_ready1), 32'd1);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, errs);
        $finish;
    end
endmodule

// File: doc/cla_word_sequencer.md
# cla_word_sequencer

Multi-precision add/subtract controller that computes NIBBLES×4-bit results by passing operands nibble by nibble through a single 4-bit carry-lookahead adder slice with registered inputs and outputs. The carry from each nibble is chained into the next. Operands enter and results leave through valid/ready handshakes. The block sits between an operand source, such as a register file or test driver, and a result consumer, and it owns the only adder slice.

## Interface
Parameters:
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES, with NIBBLES ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request valid
- in_ready  out  1  high only in IDLE
- a  in  W  operand A
- b  in  W  operand B
- cin  in  1  carry-in; used only when op=0
- op  in  1  0 = add, 1 = subtract (a − b)
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer accepts result
- sum  out  W  result
- cout  out  1  final carry; for subtract, 1 means no borrow
- busy  out  1  high in every state except IDLE

## Operation
- FSM states are IDLE, ISSUE, WAIT, COLLECT and DONE.
- IDLE:
  - On in_valid, capture a into opa and capture either b or ~b into opb, selected by op.
  - Load carry with cin when op=0, or with 1 when op=1.
  - Set idx to 0 and go to ISSUE.
- ISSUE: drive the slice with opa[4*idx+:4], opb[4*idx+:4] and carry, then go to WAIT.
- WAIT: one cycle while the slice input register feeds its output register, then go to COLLECT.
- COLLECT:
  - Write the slice S into sum[4*idx+:4] and load carry with the slice Cout.
  - If idx = NIBBLES−1, copy carry into cout and go to DONE.
  - Otherwise increment idx and go to ISSUE.
- DONE: hold sum and cout stable and keep out_valid high. When out_ready is high, go to IDLE.
- Slice inputs are driven to zero in every state except ISSUE.
- Arithmetic is modulo 2^W. The full result is {cout, sum}.
- sum is cleared to 0 on acceptance, before the first nibble is written.
- Inputs a, b, cin and op are sampled only on the accepting edge. Later changes have no effect on the operation in progress.
- No new request is accepted in DONE. The earliest new acceptance is the cycle after the DONE→IDLE edge.

## Timing
- Slice latency is 2 edges. Inputs are registered on the edge ending ISSUE; S and Cout are registered on the edge ending WAIT and are read during COLLECT.
- Each nibble costs 3 cycles. Taking cycle 0 as the accepting cycle, nibble k uses ISSUE in cycle 1+3k, WAIT in 2+3k and COLLECT in 3+3k.
- out_valid is first high in cycle 3*NIBBLES+1. For NIBBLES=4 that is cycle 13.
- Throughput is at most one operation per 3*NIBBLES+2 cycles.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0
  - sum = 0, cout = 0, idx = 0, carry = 0
  - slice registers = 0
- Reset asserted mid-operation aborts the operation. The next cycle shows reset values and the partial result is discarded.
- Reset in the same cycle as in_valid wins; the request is not accepted.
- A DONE cycle with out_ready low holds all outputs unchanged for any number of cycles.

## Structure
- Package cla_seq_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, COLLECT, DONE)
  - the op encoding constants OP_ADD = 0 and OP_SUB = 1
  - the SLICE_W = 4 constant
- Sub-module cla4_reg is the 4-bit CLA slice. It has ports clk, rst, A, B and Cin; a registered copy of its inputs; combinational generate/propagate lookahead; and registered S and Cout. It is instantiated once.
- The sequencer holds the FSM, operand registers, idx counter, carry register and the sum/cout result registers.

## Test plan
- Add with carry: NIBBLES=4, op=0, a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, out_valid first high in cycle 13.
- Add: op=0, a=0xAAAA, b=0xCCCC, cin=1 -> sum=0x7777, cout=1. A second request with a=0x000A, b=0x0008, cin=0 -> sum=0x0012, cout=0.
- Subtract: op=1, a=0x1000, b=0x0001 -> sum=0x0FFF, cout=1. Then a=0x0001, b=0x0002 -> sum=0xFFFF, cout=0 (borrow).
- Backpressure: hold out_ready low for 5 cycles in DONE -> sum, cout and out_valid stay stable. in_ready stays 0 until the cycle after out_ready is seen high.
- Reset mid-operation: assert rst in cycle 6 of an add -> the next cycle shows IDLE, in_ready=1, busy=0, sum=0, cout=0. A following 0x0003+0x0004 request gives sum=0x0007.
- Single slice: NIBBLES=1, a=0xA, b=0x8, cin=0 -> sum=0x2, cout=1, out_valid first high in cycle 4.
